regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with an issue scoreboard, the next generation of the pipeline's two-read/two-write register file. It sits between decode, which reads operands and claims destinations, and writeback, which commits results and clears claims. It adds configurable width, depth and port counts, asynchronous reset, same-cycle write-to-read bypass, and per-register busy tracking for hazard detection.

## Interface

Parameters:
- `WIDTH`, 32, data width in bits
- `NREGS`, 32, number of architectural registers; power of two, ≥ 2
- `AW`, `$clog2(NREGS)`, register address width (derived)
- `NRD`, 2, number of read ports
- `NWR`, 2, number of write ports
- `NCLM`, 1, number of scoreboard claim ports
- `SP_IDX`, 31, index of the stack-pointer register
- `SP_RESET`, `32'h0003_FFF0`, stack-pointer reset value
- `BYPASS`, 1, enables same-cycle write-to-read forwarding when 1

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `stall` in 1: holds all read outputs
- `raddr` in NRD*AW: read addresses; port k occupies `[k*AW +: AW]`
- `rdata` out NRD*WIDTH: registered read data
- `rbusy` out NRD: registered busy flag of each read address
- `wen` in NWR: write enables
- `waddr` in NWR*AW: write addresses
- `wdata` in NWR*WIDTH: write data
- `clm_en` in NCLM: claim enables (set busy)
- `clm_addr` in NCLM*AW: claim addresses
- `ret_val` out WIDTH: combinational copy of r1

## Operation

- **Storage.** `NREGS` × `WIDTH` registers plus `NREGS` busy bits.
- **r0.** Writes to r0 are dropped. Claims of r0 are dropped. A read of r0 returns 0 with busy = 0.
- **Write priority.** When two enabled write ports target the same address, the lowest-index port wins. Writes to distinct addresses all commit in the same cycle.
- **Busy clear and set.** Any enabled write clears that register's busy bit. An enabled claim sets it.
- **Claim vs. write.** A claim and a write to the same register in the same cycle leave busy = 1, because the claim belongs to the newer producer. The data is still written.
- **Read capture.** On each rising edge with `stall` = 0, every read port captures data and busy for its `raddr`.
- **Bypass.** When `BYPASS` = 1 and an enabled write in this cycle targets `raddr[k]`, `rdata[k]` captures that write's data (lowest-index writer if several) and `rbusy[k]` captures 0, unless a same-cycle claim also targets that address, in which case it captures 1.
- **No bypass.** When `BYPASS` = 0, each port captures the pre-edge array value and pre-edge busy bit.
- **Stall.** With `stall` = 1, `rdata` and `rbusy` hold their values. Writes and claims still commit.
- **`ret_val`.** Reflects the array contents of r1 without bypass.

## Timing

- **Reset.** Asynchronous on `rst_n` low. All registers go to 0 except `SP_IDX`, which goes to `SP_RESET`. All busy bits go to 0. `rdata` and `rbusy` go to 0. `ret_val` reads 0. Pending writes and claims in the reset cycle are discarded.
- **Reset release.** Takes effect on the first rising edge with `rst_n` high.
- **Read latency.** One cycle from `raddr` to `rdata` and `rbusy`.
- **Write latency.** A write is visible to a non-bypassed read issued in the following cycle.
- **Claim latency.** A claim is visible in `rbusy` one cycle after it is presented, or in the same capture if bypassed.
- **Boundary addresses.** Address `NREGS-1` is valid. There are no out-of-range addresses because `AW` is exact.

## Structure

- **Shared package** `dioptase_pkg`: `RAM_BYTES` (`32'h0004_0000`), `STACK_PTR_RESET` (`RAM_BYTES - 32'h10`), `REG_W` = 32, `REG_AW` = 5. `SP_RESET` defaults to `dioptase_pkg::STACK_PTR_RESET`.
- **Sub-module** `reg_scoreboard`: holds the `NREGS`-bit busy vector with claim/clear ports and the claim-over-clear rule, and provides per-read-port lookup.
- **Top level:** data array, write-priority resolution and bypass muxes stay in `regfile_mp`.

## Test plan

- **Reset:** assert `rst_n` = 0 mid-run → all `rdata` = 0, `rbusy` = 0; after release, a read of r31 returns `0x0003_FFF0` and a read of r5 returns 0.
- **Write conflict:** write port 0 r7 = `0xAAAA_0001` and port 1 r7 = `0xBBBB_0002` in the same cycle → the next-cycle read of r7 returns `0xAAAA_0001`. Port 0 r3 = 5 with port 1 r4 = 9 → both commit.
- **Bypass:** with `BYPASS` = 1, write r9 = `0x1234` while `raddr0` = 9 → `rdata0` = `0x1234` next cycle. With `BYPASS` = 0 the same stimulus returns the old value, then `0x1234` one cycle later.
- **Scoreboard:** claim r12 → `rbusy` for r12 = 1. Write r12 → 0. Claim and write r12 in the same cycle → 1. Claim r0 → r0 busy stays 0.
- **r0 and `ret_val`:** write r0 = `0xFFFF_FFFF` → r0 reads 0. Write r1 = 42 → `ret_val` = 42 after the edge.
- **Stall:** `stall` = 1 for 3 cycles while r2 is written with 7 → `rdata` holds its prior value. After `stall` falls, r2 reads 7.

Source files
------------

// File: rtl/dioptase_pkg.sv
// dioptase_pkg: shared machine constants for the core register file and memory map.
// Latency: n/a (constants only).
// Backpressure: n/a.
package dioptase_pkg;
   localparam logic [31:0] RAM_BYTES       = 32'h0004_0000;
   localparam logic [31:0] STACK_PTR_RESET = RAM_BYTES - 32'h10;
   localparam int          REG_W           = 32;
   localparam int          REG_AW          = 5;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits; claims set, writes clear, claim wins over a same-cycle clear.
// Latency: busy updates on the next edge; o_busy_nxt exposes the post-edge value for same-cycle forwarding.
// Backpressure: none; every claim and clear presented is applied.
module reg_scoreboard
   import dioptase_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS),
   parameter int NRD   = 2,
   parameter int NWR   = 2,
   parameter int NCLM  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NWR-1:0]    i_clr_en,
   input  logic [NWR*AW-1:0] i_clr_addr,
   input  logic [NCLM-1:0]   i_set_en,
   input  logic [NCLM*AW-1:0] i_set_addr,
   input  logic [NRD*AW-1:0] i_raddr,
   output logic [NRD-1:0]    o_busy_cur,
   output logic [NRD-1:0]    o_busy_nxt
);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // Next busy vector: clears first, then claims override (the claim belongs to the newer producer).
   always_comb begin
      w_busy_nxt = r_busy;
      for (int j = 0; j < NWR; j++) begin
         if (i_clr_en[j]) w_busy_nxt[i_clr_addr[j*AW +: AW]] = 1'b0;
      end
      for (int c = 0; c < NCLM; c++) begin
         if (i_set_en[c]) w_busy_nxt[i_set_addr[c*AW +: AW]] = 1'b1;
      end
      // r0 is never a real producer target, so it can never be busy.
      w_busy_nxt[0] = 1'b0;
   end

   // Busy state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_busy <= '0;
      else        r_busy <= w_busy_nxt;
   end

   // Per-read-port lookup of both the current and the post-edge busy bit.
   always_comb begin
      o_busy_cur = '0;
      o_busy_nxt = '0;
      for (int k = 0; k < NRD; k++) begin
         o_busy_cur[k] = r_busy[i_raddr[k*AW +: AW]];
         o_busy_nxt[k] = w_busy_nxt[i_raddr[k*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with issue scoreboard and optional write-to-read bypass.
// Latency: 1 cycle raddr -> rdata/rbusy; writes visible to the next read; ret_val is combinational.
// Backpressure: stall freezes rdata/rbusy only; writes and claims always commit.
module regfile_mp
   import dioptase_pkg::*;
#(
   parameter int               WIDTH    = REG_W,
   parameter int               NREGS    = 32,
   parameter int               AW       = $clog2(NREGS),
   parameter int               NRD      = 2,
   parameter int               NWR      = 2,
   parameter int               NCLM     = 1,
   parameter int               SP_IDX   = 31,
   parameter logic [WIDTH-1:0] SP_RESET = STACK_PTR_RESET,
   parameter bit               BYPASS   = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic [NRD*AW-1:0]     raddr,
   output logic [NRD*WIDTH-1:0]  rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic [NWR-1:0]        wen,
   input  logic [NWR*AW-1:0]     waddr,
   input  logic [NWR*WIDTH-1:0]  wdata,
   input  logic [NCLM-1:0]       clm_en,
   input  logic [NCLM*AW-1:0]    clm_addr,
   output logic [WIDTH-1:0]      ret_val
);

   logic [WIDTH-1:0]     r_mem [NREGS];
   logic [NRD*WIDTH-1:0] r_rdata;
   logic [NRD-1:0]       r_rbusy;

   logic [NRD-1:0]       w_bsy_cur;
   logic [NRD-1:0]       w_bsy_nxt;
   logic [NRD*WIDTH-1:0] w_rd_dat;
   logic [NRD-1:0]       w_rd_bsy;
   logic [NWR-1:0]       w_wr_ok;
   logic [NCLM-1:0]      w_clm_ok;

   // Drop writes and claims that target r0.
   always_comb begin
      w_wr_ok  = '0;
      w_clm_ok = '0;
      for (int j = 0; j < NWR; j++)  w_wr_ok[j]  = wen[j] && (waddr[j*AW +: AW] != '0);
      for (int c = 0; c < NCLM; c++) w_clm_ok[c] = clm_en[c] && (clm_addr[c*AW +: AW] != '0);
   end

   reg_scoreboard #(
      .NREGS (NREGS),
      .AW    (AW),
      .NRD   (NRD),
      .NWR   (NWR),
      .NCLM  (NCLM)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr_en   (w_wr_ok),
      .i_clr_addr (waddr),
      .i_set_en   (w_clm_ok),
      .i_set_addr (clm_addr),
      .i_raddr    (raddr),
      .o_busy_cur (w_bsy_cur),
      .o_busy_nxt (w_bsy_nxt)
   );

   // Data array; ports are applied high to low so the lowest-index writer lands last and wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) r_mem[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end else begin
         for (int j = NWR - 1; j >= 0; j--) begin
            if (w_wr_ok[j]) r_mem[waddr[j*AW +: AW]] <= wdata[j*WIDTH +: WIDTH];
         end
      end
   end

   // Read mux: array value, optionally overridden by the lowest-index same-cycle writer.
   always_comb begin
      w_rd_dat = '0;
      w_rd_bsy = '0;
      for (int k = 0; k < NRD; k++) begin
         w_rd_dat[k*WIDTH +: WIDTH] = r_mem[raddr[k*AW +: AW]];
         w_rd_bsy[k]                = w_bsy_cur[k];
         if (BYPASS) begin
            w_rd_bsy[k] = w_bsy_nxt[k];
            for (int j = NWR - 1; j >= 0; j--) begin
               if (w_wr_ok[j] && (waddr[j*AW +: AW] == raddr[k*AW +: AW]))
                  w_rd_dat[k*WIDTH +: WIDTH] = wdata[j*WIDTH +: WIDTH];
            end
         end
      end
   end

   // Registered read outputs, frozen while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdata <= '0;
         r_rbusy <= '0;
      end else if (!stall) begin
         r_rdata <= w_rd_dat;
         r_rbusy <= w_rd_bsy;
      end
   end

   assign rdata   = r_rdata;
   assign rbusy   = r_rbusy;
   assign ret_val = r_mem[1];

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: checks a bypassing and a non-bypassing regfile_mp against an array-level model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: stall exercised in directed and random phases.
module tb_regfile_mp;
   localparam int W  = 32;
   localparam int N  = 32;
   localparam int AW = 5;
   localparam logic [W-1:0] SP = 32'h0003_FFF0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic [2*AW-1:0] raddr = '0;
   logic [1:0] wen = '0;
   logic [2*AW-1:0] waddr = '0;
   logic [2*W-1:0] wdata = '0;
   logic [0:0] clm_en = '0;
   logic [AW-1:0] clm_addr = '0;

   logic [2*W-1:0] rdata_b, rdata_n;
   logic [1:0] rbusy_b, rbusy_n;
   logic [W-1:0] ret_b, ret_n;

   int total = 0;
   int bad = 0;

   logic [W-1:0] m_mem [N];
   logic m_busy [N];
   logic [W-1:0] e_dat_b [2];
   logic [W-1:0] e_dat_n [2];
   logic e_bsy_b [2];
   logic e_bsy_n [2];

   always #5 clk = ~clk;

   regfile_mp #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .stall(stall), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
      .wen(wen), .waddr(waddr), .wdata(wdata), .clm_en(clm_en), .clm_addr(clm_addr), .ret_val(ret_b)
   );

   regfile_mp #(.BYPASS(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n), .stall(stall), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
      .wen(wen), .waddr(waddr), .wdata(wdata), .clm_en(clm_en), .clm_addr(clm_addr), .ret_val(ret_n)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_mem[i]  = (i == 31) ? SP : '0;
         m_busy[i] = 1'b0;
      end
      for (int k = 0; k < 2; k++) begin
         e_dat_b[k] = '0; e_dat_n[k] = '0; e_bsy_b[k] = 1'b0; e_bsy_n[k] = 1'b0;
      end
   endtask

   task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      raddr = {a1, a0};
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [W-1:0] d);
      wen[p] = 1'b1;
      waddr[p*AW +: AW] = a;
      wdata[p*W +: W] = d;
   endtask

   task automatic clm(input logic [AW-1:0] a);
      clm_en = 1'b1;
      clm_addr = a;
   endtask

   task automatic quiet();
      wen = '0;
      clm_en = '0;
   endtask

   // One clock: derive the post-edge register state from the rules, then compare every output.
   task automatic step();
      logic [W-1:0] mn [N];
      logic bn [N];
      logic [AW-1:0] a;
      logic taken [N];
      mn = m_mem;
      bn = m_busy;
      for (int i = 0; i < N; i++) taken[i] = 1'b0;
      for (int j = 0; j < 2; j++) begin
         a = waddr[j*AW +: AW];
         if (wen[j] && a != 0) begin
            if (!taken[a]) mn[a] = wdata[j*W +: W];
            taken[a] = 1'b1;
            bn[a] = 1'b0;
         end
      end
      if (clm_en[0] && clm_addr != 0) bn[clm_addr] = 1'b1;
      if (!stall) begin
         for (int k = 0; k < 2; k++) begin
            a = raddr[k*AW +: AW];
            e_dat_b[k] = mn[a];
            e_bsy_b[k] = bn[a];
            e_dat_n[k] = m_mem[a];
            e_bsy_n[k] = m_busy[a];
         end
      end
      @(posedge clk);
      #1;
      m_mem = mn;
      m_busy = bn;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rdata_byp[%0d]", k), rdata_b[k*W +: W], e_dat_b[k]);
         chk($sformatf("rbusy_byp[%0d]", k), {31'b0, rbusy_b[k]}, {31'b0, e_bsy_b[k]});
         chk($sformatf("rdata_nobyp[%0d]", k), rdata_n[k*W +: W], e_dat_n[k]);
         chk($sformatf("rbusy_nobyp[%0d]", k), {31'b0, rbusy_n[k]}, {31'b0, e_bsy_n[k]});
      end
      chk("ret_val_byp", ret_b, m_mem[1]);
      chk("ret_val_nobyp", ret_n, m_mem[1]);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_rdata_byp"}, rdata_b[W-1:0] | rdata_b[2*W-1:W], '0);
      chk({tag, "_rdata_nobyp"}, rdata_n[W-1:0] | rdata_n[2*W-1:W], '0);
      chk({tag, "_rbusy"}, {30'b0, rbusy_b | rbusy_n}, '0);
      chk({tag, "_ret_val"}, ret_b | ret_n, '0);
   endtask

   function automatic logic [AW-1:0] pick();
      case ($urandom_range(0, 4))
         0: return '0;
         1: return 5'd31;
         default: return 5'($urandom_range(1, 6));
      endcase
   endfunction

   initial begin
      // Power-on reset.
      #12;
      chk_zero_outputs("por");
      model_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset values of SP and an ordinary register.
      rd(5'd31, 5'd5);
      step();
      chk("sp_reset", rdata_b[W-1:0], SP);
      chk("r5_reset", rdata_b[2*W-1:W], '0);

      // Write conflict: lowest port wins.
      rd(5'd0, 5'd0);
      wr(0, 5'd7, 32'hAAAA_0001); wr(1, 5'd7, 32'hBBBB_0002);
      step();
      quiet(); rd(5'd7, 5'd0);
      step();
      chk("conflict_byp", rdata_b[W-1:0], 32'hAAAA_0001);
      chk("conflict_nobyp", rdata_n[W-1:0], 32'hAAAA_0001);

      // Distinct addresses both commit.
      wr(0, 5'd3, 32'd5); wr(1, 5'd4, 32'd9);
      step();
      quiet(); rd(5'd3, 5'd4);
      step();
      chk("dual_wr_p0", rdata_n[W-1:0], 32'd5);
      chk("dual_wr_p1", rdata_n[2*W-1:W], 32'd9);

      // Bypass versus no bypass.
      rd(5'd9, 5'd0);
      wr(0, 5'd9, 32'h1234);
      step();
      chk("bypass_hit", rdata_b[W-1:0], 32'h1234);
      chk("nobypass_old", rdata_n[W-1:0], 32'h0);
      quiet();
      step();
      chk("nobypass_late", rdata_n[W-1:0], 32'h1234);

      // Scoreboard: claim, clear, claim-with-write, claim of r0.
      rd(5'd12, 5'd0);
      clm(5'd12);
      step();
      chk("claim_byp", {31'b0, rbusy_b[0]}, 32'd1);
      chk("claim_nobyp_pre", {31'b0, rbusy_n[0]}, 32'd0);
      quiet();
      step();
      chk("claim_nobyp", {31'b0, rbusy_n[0]}, 32'd1);
      wr(0, 5'd12, 32'h55);
      step();
      chk("clear_byp", {31'b0, rbusy_b[0]}, 32'd0);
      quiet();
      step();
      chk("clear_nobyp", {31'b0, rbusy_n[0]}, 32'd0);
      wr(1, 5'd12, 32'h66); clm(5'd12);
      step();
      chk("claim_wins_byp", {31'b0, rbusy_b[0]}, 32'd1);
      chk("claim_wins_dat", rdata_b[W-1:0], 32'h66);
      quiet();
      step();
      chk("claim_wins_nobyp", {31'b0, rbusy_n[0]}, 32'd1);
      rd(5'd0, 5'd12);
      clm(5'd0);
      step();
      quiet();
      step();
      chk("claim_r0", {31'b0, rbusy_b[0] | rbusy_n[0]}, 32'd0);

      // r0 write dropped; ret_val follows r1.
      wr(0, 5'd0, 32'hFFFF_FFFF);
      step();
      chk("r0_byp", rdata_b[W-1:0], 32'h0);
      quiet();
      step();
      chk("r0_nobyp", rdata_n[W-1:0], 32'h0);
      wr(1, 5'd1, 32'd42);
      step();
      chk("ret_val_42", ret_b, 32'd42);
      quiet();

      // Stall holds outputs while writes still commit.
      rd(5'd2, 5'd1);
      step();
      stall = 1'b1;
      wr(0, 5'd2, 32'd7);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_hold", rdata_b[W-1:0], 32'h0);
      end
      stall = 1'b0;
      quiet();
      step();
      chk("after_stall", rdata_n[W-1:0], 32'd7);

      // Mid-run asynchronous reset; writes and claims presented during reset are discarded.
      #2;
      wr(0, 5'd5, 32'hDEAD_BEEF); clm(5'd6);
      rst_n = 1'b0;
      #2;
      chk_zero_outputs("midrst");
      model_reset();
      @(posedge clk); #1;
      quiet();
      rst_n = 1'b1;
      rd(5'd31, 5'd5);
      step();
      chk("midrst_sp", rdata_n[W-1:0], SP);
      chk("midrst_r5", rdata_n[2*W-1:W], 32'h0);
      rd(5'd6, 5'd2);
      step();
      chk("midrst_r6_busy", {31'b0, rbusy_n[0]}, 32'd0);
      chk("midrst_r2", rdata_n[2*W-1:W], 32'h0);

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         stall = ($urandom_range(0, 7) == 0);
         rd(pick(), pick());
         quiet();
         for (int p = 0; p < 2; p++) begin
            if ($urandom_range(0, 1) == 1) wr(p, pick(), $urandom);
         end
         if ($urandom_range(0, 2) == 0) clm(pick());
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
